// File: rtl/piano_kbd_pkg.sv
// Shared definitions for the PS/2 piano keyboard tracker: scan codes, key index type,
// decoder state encoding and the scan-code-to-key lookup.
package piano_kbd_pkg;

  localparam logic [7:0] CodeA = 8'h1C;
  localparam logic [7:0] CodeB = 8'h32;
  localparam logic [7:0] CodeC = 8'h21;
  localparam logic [7:0] CodeD = 8'h23;
  localparam logic [7:0] CodeE = 8'h24;
  localparam logic [7:0] CodeF = 8'h2B;
  localparam logic [7:0] CodeG = 8'h34;
  localparam logic [7:0] BREAK = 8'hF0;
  localparam logic [7:0] EXT   = 8'hE0;

  typedef logic [2:0] key_idx_t;

  typedef enum logic [1:0] {StIdle, StBrk, StExt, StExtBrk} dec_state_e;

  typedef struct packed {
    logic     valid;
    key_idx_t idx;
  } key_map_t;

  function automatic key_map_t code_to_idx(input logic [7:0] code);
    key_map_t m;
    m.valid = 1'b1;
    m.idx   = '0;
    case (code)
      CodeA:   m.idx = 3'd0;
      CodeB:   m.idx = 3'd1;
      CodeC:   m.idx = 3'd2;
      CodeD:   m.idx = 3'd3;
      CodeE:   m.idx = 3'd4;
      CodeF:   m.idx = 3'd5;
      CodeG:   m.idx = 3'd6;
      default: m.valid = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_key_tracker_if.sv
// Byte stream in from the PS/2 receiver, key state and change pulse out to the renderer.
interface ps2_key_tracker_if;
  logic [7:0] ps2_byte;
  logic       ps2_valid;
  logic [6:0] keyNum;
  logic       newPress;
  logic       overflow;

  modport master (output ps2_byte, ps2_valid, input keyNum, newPress, overflow);
  modport slave  (input ps2_byte, ps2_valid, output keyNum, newPress, overflow);
endinterface

// File: rtl/key_event_fifo.sv
// Synchronous FIFO of pending key indices; a push into a full FIFO is accepted when a pop
// happens in the same cycle.
module key_event_fifo
  import piano_kbd_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     push_i,
  input  key_idx_t wdata_i,
  input  logic     pop_i,
  output key_idx_t rdata_o,
  output logic     full_o,
  output logic     empty_o
);
  localparam int unsigned Aw = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [Aw:0] FullCount = Depth[Aw:0];

  key_idx_t        mem_q [Depth];
  logic [Aw-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [Aw:0]     count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == FullCount);
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = do_pop ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Reset is synchronous to match the rest of the codebase.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// Turns PS/2 set-2 scan codes for A-G into single-bit keyNum changes, one per newPress,
// spaced HOLDOFF cycles apart so each key redraw completes before the next begins.
module ps2_key_tracker
  import piano_kbd_pkg::*;
#(
  parameter int unsigned HOLDOFF    = 600,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic               CLOCK_50,
  input logic               Resetn,
  ps2_key_tracker_if.slave  kbd
);
  localparam int unsigned CntW = $clog2(HOLDOFF);
  localparam logic [CntW-1:0] CntLoad = CntW'(HOLDOFF - 1);

  dec_state_e      state_q, state_d;
  logic [6:0]      shadow_q, shadow_d;
  logic [6:0]      key_q, key_d;
  logic            new_press_q, new_press_d;
  logic            overflow_q, overflow_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  key_map_t map;
  logic     ev_valid, ev_target, push_req;
  logic     fifo_push, fifo_pop, fifo_full, fifo_empty, bypass, accepted, emit;
  key_idx_t fifo_head, emit_idx;

  key_event_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLOCK_50),
    .rst_ni  (Resetn),
    .push_i  (fifo_push),
    .wdata_i (map.idx),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    ev_valid  = 1'b0;
    ev_target = 1'b0;
    map       = code_to_idx(kbd.ps2_byte);
    if (kbd.ps2_valid) begin
      unique case (state_q)
        StIdle: begin
          if (kbd.ps2_byte == BREAK) begin
            state_d = StBrk;
          end else if (kbd.ps2_byte == EXT) begin
            state_d = StExt;
          end else if (map.valid) begin
            ev_valid  = 1'b1;
            ev_target = 1'b1;
          end
        end
        StBrk: begin
          state_d  = StIdle;
          ev_valid = map.valid;
        end
        StExt:    state_d = (kbd.ps2_byte == BREAK) ? StExtBrk : StIdle;
        StExtBrk: state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  // An empty FIFO with an idle counter forwards the event straight to the outputs, giving
  // newPress in the cycle right after the byte instead of one cycle later.
  always_comb begin
    push_req  = ev_valid && (shadow_q[map.idx] != ev_target);
    fifo_pop  = (cnt_q == '0) && !fifo_empty;
    bypass    = (cnt_q == '0) && fifo_empty && push_req;
    fifo_push = push_req && !bypass && (!fifo_full || fifo_pop);
    accepted  = bypass || fifo_push;
    emit      = fifo_pop || bypass;
    emit_idx  = fifo_pop ? fifo_head : map.idx;

    shadow_d = shadow_q;
    if (accepted) shadow_d[map.idx] = ev_target;
    overflow_d = overflow_q | (push_req & ~accepted);

    key_d = key_q;
    if (emit) key_d[emit_idx] = ~key_q[emit_idx];
    new_press_d = emit;

    cnt_d = cnt_q;
    if (emit) begin
      cnt_d = CntLoad;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      state_q     <= StIdle;
      shadow_q    <= '0;
      key_q       <= '0;
      new_press_q <= 1'b0;
      overflow_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      key_q       <= key_d;
      new_press_q <= new_press_d;
      overflow_q  <= overflow_d;
      cnt_q       <= cnt_d;
    end
  end

  assign kbd.keyNum   = key_q;
  assign kbd.newPress = new_press_q;
  assign kbd.overflow = overflow_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed scenarios for ps2_key_tracker; a negedge monitor logs every newPress pulse.
module tb_ps2_key_tracker;
  localparam int unsigned Holdoff = 600;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;
  int   cyc;
  int         pulse_cyc[$];
  logic [6:0] pulse_key[$];

  ps2_key_tracker_if kbd ();

  ps2_key_tracker #(
    .HOLDOFF    (Holdoff),
    .FIFO_DEPTH (4)
  ) dut (
    .CLOCK_50 (clk),
    .Resetn   (rst_n),
    .kbd      (kbd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (rst_n && kbd.newPress === 1'b1) begin
      pulse_cyc.push_back(cyc);
      pulse_key.push_back(kbd.keyNum);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    kbd.ps2_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulse_cyc.delete();
    pulse_key.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    kbd.ps2_byte  = b;
    kbd.ps2_valid = 1'b1;
    @(negedge clk);
    kbd.ps2_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (kbd.keyNum !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_keyNum: got %b want %b", kbd.keyNum, 7'b0);
    end
    tests_run++;
    if (kbd.newPress !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_newPress: got %b want 0", kbd.newPress);
    end
    tests_run++;
    if (kbd.overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_overflow: got %b want 0", kbd.overflow);
    end
  endtask

  task automatic test_press_release();
    do_reset();
    send_byte(8'h1C);
    tests_run++;
    if (kbd.newPress !== 1'b1 || kbd.keyNum !== 7'b0000001) begin
      tests_failed++;
      $display("FAIL press_latency: got newPress=%b keyNum=%b want 1 0000001",
               kbd.newPress, kbd.keyNum);
    end
    send_byte(8'hF0);
    send_byte(8'h1C);
    idle(Holdoff + 50);
    tests_run++;
    if (pulse_key.size() !== 2) begin
      tests_failed++;
      $display("FAIL press_release_count: got %0d pulses want 2", pulse_key.size());
    end else begin
      tests_run++;
      if (pulse_cyc[1] - pulse_cyc[0] !== Holdoff) begin
        tests_failed++;
        $display("FAIL press_release_gap: got %0d want %0d", pulse_cyc[1] - pulse_cyc[0],
                 Holdoff);
      end
      tests_run++;
      if (pulse_key[1] !== 7'b0000000) begin
        tests_failed++;
        $display("FAIL release_keyNum: got %b want 0000000", pulse_key[1]);
      end
    end
  endtask

  task automatic test_typematic();
    do_reset();
    repeat (5) send_byte(8'h21);
    send_byte(8'hF0);
    send_byte(8'h21);
    idle(2 * Holdoff);
    tests_run++;
    if (pulse_key.size() !== 2) begin
      tests_failed++;
      $display("FAIL typematic_count: got %0d pulses want 2", pulse_key.size());
    end else begin
      tests_run++;
      if (pulse_key[0] !== 7'b0000100 || pulse_key[1] !== 7'b0000000) begin
        tests_failed++;
        $display("FAIL typematic_keys: got %b,%b want 0000100,0000000", pulse_key[0],
                 pulse_key[1]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp_keys [4];
    exp_keys[0] = 7'b0000100;
    exp_keys[1] = 7'b0001100;
    exp_keys[2] = 7'b0011100;
    exp_keys[3] = 7'b0111100;
    do_reset();
    send_byte(8'h21);
    send_byte(8'h23);
    send_byte(8'h24);
    send_byte(8'h2B);
    idle(4 * Holdoff);
    tests_run++;
    if (pulse_key.size() !== 4) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d pulses want 4", pulse_key.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (pulse_key[i] !== exp_keys[i]) begin
          tests_failed++;
          $display("FAIL b2b_key%0d: got %b want %b", i, pulse_key[i], exp_keys[i]);
        end
        if (i > 0) begin
          tests_run++;
          if (pulse_cyc[i] - pulse_cyc[i-1] !== Holdoff) begin
            tests_failed++;
            $display("FAIL b2b_gap%0d: got %0d want %0d", i, pulse_cyc[i] - pulse_cyc[i-1],
                     Holdoff);
          end
        end
      end
    end
    tests_run++;
    if (kbd.overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_overflow: got %b want 0", kbd.overflow);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    send_byte(8'h1C);
    send_byte(8'h32);
    send_byte(8'h21);
    send_byte(8'h23);
    send_byte(8'h24);
    send_byte(8'h2B);
    tests_run++;
    if (kbd.overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL overflow_flag: got %b want 1", kbd.overflow);
    end
    idle(5 * Holdoff);
    tests_run++;
    if (pulse_key.size() !== 5) begin
      tests_failed++;
      $display("FAIL overflow_count: got %0d pulses want 5", pulse_key.size());
    end
    tests_run++;
    if (kbd.keyNum !== 7'b0011111) begin
      tests_failed++;
      $display("FAIL overflow_final_key: got %b want 0011111", kbd.keyNum);
    end
    // One-cycle reset must clear the sticky flag.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tests_run++;
    if (kbd.overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL overflow_cleared: got %b want 0", kbd.overflow);
    end
  endtask

  task automatic test_extended();
    do_reset();
    send_byte(8'hE0);
    send_byte(8'h1C);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h1C);
    idle(20);
    tests_run++;
    if (pulse_key.size() !== 0 || kbd.keyNum !== 7'b0) begin
      tests_failed++;
      $display("FAIL extended_ignored: got %0d pulses keyNum=%b want 0 0000000",
               pulse_key.size(), kbd.keyNum);
    end
    send_byte(8'h34);
    tests_run++;
    if (kbd.newPress !== 1'b1 || kbd.keyNum !== 7'b1000000) begin
      tests_failed++;
      $display("FAIL extended_then_g: got newPress=%b keyNum=%b want 1 1000000",
               kbd.newPress, kbd.keyNum);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_byte(8'h1C);
    send_byte(8'h32);
    send_byte(8'h21);
    idle(100);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pulse_cyc.delete();
    pulse_key.delete();
    tests_run++;
    if (kbd.keyNum !== 7'b0 || kbd.newPress !== 1'b0 || kbd.overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: got keyNum=%b newPress=%b overflow=%b want all 0",
               kbd.keyNum, kbd.newPress, kbd.overflow);
    end
    idle(2 * Holdoff + 100);
    tests_run++;
    if (pulse_key.size() !== 0) begin
      tests_failed++;
      $display("FAIL midreset_no_pulses: got %0d pulses want 0", pulse_key.size());
    end
    // Counter and shadow cleared: a fresh press emits immediately.
    send_byte(8'h32);
    tests_run++;
    if (kbd.newPress !== 1'b1 || kbd.keyNum !== 7'b0000010) begin
      tests_failed++;
      $display("FAIL midreset_fresh_press: got newPress=%b keyNum=%b want 1 0000010",
               kbd.newPress, kbd.keyNum);
    end
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    cyc           = 0;
    rst_n         = 1'b0;
    kbd.ps2_byte  = 8'h00;
    kbd.ps2_valid = 1'b0;
    test_reset();
    test_press_release();
    test_typematic();
    test_back_to_back();
    test_overflow();
    test_extended();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
